rom_fetch_arb: RTL and testbench

Single-port access controller for the instruction ROM. Arbitrates between the CPU instruction-fetch port and a debug/readback port so that exactly one word-aligned ROM read is issued per cycle. Returns registered read data with a valid strobe to the winning requester. Sits between the fetch stage, the debug loader and the combinational ROM.

---
 rtl/rom_fetch_arb_if.sv | 27 ++
 rtl/rom_fetch_arb.sv | 93 +++++++++
 tb/tb_rom_fetch_arb.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/rom_fetch_arb_if.sv
// Request/response bundle between the fetch stage, debug loader, ROM and rom_fetch_arb.
// master = requesters plus ROM model side; slave = arbiter side.
interface rom_fetch_arb_if;
  logic        cpu_req;
  logic [31:0] cpu_addr;
  logic        cpu_gnt;
  logic        cpu_rvalid;
  logic [31:0] cpu_rdata;
  logic        dbg_req;
  logic [31:0] dbg_addr;
  logic        dbg_gnt;
  logic        dbg_rvalid;
  logic [31:0] dbg_rdata;
  logic [31:0] rom_addr;
  logic [31:0] rom_data;
  logic        err;

  modport master (
    output cpu_req, cpu_addr, dbg_req, dbg_addr, rom_data,
    input  cpu_gnt, cpu_rvalid, cpu_rdata, dbg_gnt, dbg_rvalid, dbg_rdata, rom_addr, err
  );

  modport slave (
    input  cpu_req, cpu_addr, dbg_req, dbg_addr, rom_data,
    output cpu_gnt, cpu_rvalid, cpu_rdata, dbg_gnt, dbg_rvalid, dbg_rdata, rom_addr, err
  );
endinterface

// File: rtl/rom_fetch_arb.sv
// Single-port ROM arbiter, CPU fetch vs debug readback (debug present only with ROM_ARB_DBG_EN).
// Grant in cycle N, registered rdata/rvalid/err in N+1; no backpressure, requesters hold req until gnt.
module rom_fetch_arb #(
  parameter int ROM_WORDS  = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  rom_fetch_arb_if.slave bus
);
  localparam logic [1:0] OWN_IDLE = 2'd0;
  localparam logic [1:0] OWN_CPU  = 2'd1;

  logic        cpu_win;
  logic        any_win;
  logic [31:0] sel_addr;
  logic        addr_err;
  logic [31:0] resp_dat;
  logic [1:0]  own;
  logic [1:0]  own_nxt;
  logic [31:0] cpu_rdata_q;
  logic        err_q;

`ifdef ROM_ARB_DBG_EN
  localparam logic [1:0] OWN_DBG    = 2'd2;
  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  logic        dbg_win;
  logic        starve_hit;
  logic [3:0]  starve_cnt;
  logic [31:0] dbg_rdata_q;

  // A starved debug request pre-empts the CPU for exactly one cycle.
  assign starve_hit = bus.dbg_req && (starve_cnt == STARVE_LIM);
  assign dbg_win    = starve_hit || (bus.dbg_req && !bus.cpu_req);
  assign cpu_win    = bus.cpu_req && !starve_hit;
  assign any_win    = cpu_win || dbg_win;
  assign sel_addr   = cpu_win ? bus.cpu_addr : (dbg_win ? bus.dbg_addr : 32'h0);
  assign own_nxt    = cpu_win ? OWN_CPU : (dbg_win ? OWN_DBG : OWN_IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_cnt  <= 4'd0;
      dbg_rdata_q <= 32'h0;
    end else begin
      if (bus.dbg_req && !dbg_win) begin
        if (starve_cnt != STARVE_LIM) starve_cnt <= starve_cnt + 4'd1;
      end else begin
        starve_cnt <= 4'd0;
      end
      if (dbg_win) dbg_rdata_q <= resp_dat;
    end
  end

  assign bus.dbg_gnt    = dbg_win;
  assign bus.dbg_rvalid = (own == OWN_DBG);
  assign bus.dbg_rdata  = dbg_rdata_q;
`else
  logic unused_dbg;

  assign unused_dbg     = ^{bus.dbg_req, bus.dbg_addr, 1'(STARVE_MAX)};
  assign cpu_win        = bus.cpu_req;
  assign any_win        = cpu_win;
  assign sel_addr       = cpu_win ? bus.cpu_addr : 32'h0;
  assign own_nxt        = cpu_win ? OWN_CPU : OWN_IDLE;
  assign bus.dbg_gnt    = 1'b0;
  assign bus.dbg_rvalid = 1'b0;
  assign bus.dbg_rdata  = 32'h0;
`endif

  // Bad addresses still go out on rom_addr; only the returned word is squashed.
  assign addr_err = (sel_addr[1:0] != 2'b00) ||
                    ({2'b00, sel_addr[31:2]} >= 32'(ROM_WORDS));
  assign resp_dat = addr_err ? 32'h0 : bus.rom_data;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      own         <= OWN_IDLE;
      cpu_rdata_q <= 32'h0;
      err_q       <= 1'b0;
    end else begin
      own   <= own_nxt;
      err_q <= any_win && addr_err;
      if (cpu_win) cpu_rdata_q <= resp_dat;
    end
  end

  assign bus.cpu_gnt    = cpu_win;
  assign bus.cpu_rvalid = (own == OWN_CPU);
  assign bus.cpu_rdata  = cpu_rdata_q;
  assign bus.rom_addr   = sel_addr;
  assign bus.err        = err_q;
endmodule

// File: tb/tb_rom_fetch_arb.sv
// Directed bench for rom_fetch_arb: vector table for CPU fetch/error cases plus reset and arbitration sequences.
module tb_rom_fetch_arb;
  logic clk = 1'b0;
  logic rst_n;
  int   checks   = 0;
  int   failures = 0;

  rom_fetch_arb_if bus ();

  rom_fetch_arb #(.ROM_WORDS(32), .STARVE_MAX(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // ROM contents: word index i holds 0x20020005 + (i << 16).
  function automatic logic [31:0] rom_word(input logic [31:0] a);
    return 32'h20020005 + {a[17:2], 16'h0000};
  endfunction

  always_comb bus.rom_data = rom_word(bus.rom_addr);

  typedef struct {
    logic        cpu_req;
    logic [31:0] cpu_addr;
    logic        exp_gnt;
    logic [31:0] exp_rom_addr;
    logic        exp_rvalid;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  initial begin
    bus.cpu_req  = 1'b0;
    bus.cpu_addr = 32'h0;
    bus.dbg_req  = 1'b0;
    bus.dbg_addr = 32'h0;
    rst_n        = 1'b0;

    vecs[0] = '{1'b1, 32'h0000_0000, 1'b1, 32'h0000_0000, 1'b1, 32'h2002_0005, 1'b0};
    vecs[1] = '{1'b1, 32'h0000_0004, 1'b1, 32'h0000_0004, 1'b1, 32'h2003_0005, 1'b0};
    vecs[2] = '{1'b1, 32'h0000_0008, 1'b1, 32'h0000_0008, 1'b1, 32'h2004_0005, 1'b0};
    vecs[3] = '{1'b0, 32'h0000_0000, 1'b0, 32'h0000_0000, 1'b0, 32'h2004_0005, 1'b0};
    vecs[4] = '{1'b1, 32'h0000_0006, 1'b1, 32'h0000_0006, 1'b1, 32'h0000_0000, 1'b1};
    vecs[5] = '{1'b1, 32'h0000_0080, 1'b1, 32'h0000_0080, 1'b1, 32'h0000_0000, 1'b1};
    vecs[6] = '{1'b1, 32'h0000_007C, 1'b1, 32'h0000_007C, 1'b1, 32'h2021_0005, 1'b0};
    vecs[7] = '{1'b0, 32'h0000_0000, 1'b0, 32'h0000_0000, 1'b0, 32'h2021_0005, 1'b0};

    // Grant and rom_addr are combinational even while in reset; responses are not.
    #1;
    bus.cpu_req  = 1'b1;
    bus.cpu_addr = 32'h4;
    #1;
    chk("rst_cpu_gnt", bus.cpu_gnt, 1);
    chk("rst_rom_addr", bus.rom_addr, 32'h4);
    @(posedge clk); #1;
    chk("rst_cpu_rvalid", bus.cpu_rvalid, 0);
    chk("rst_cpu_rdata", bus.cpu_rdata, 0);
    chk("rst_err", bus.err, 0);
    chk("rst_dbg_rvalid", bus.dbg_rvalid, 0);
    chk("rst_dbg_rdata", bus.dbg_rdata, 0);
    bus.cpu_req  = 1'b0;
    bus.cpu_addr = 32'h0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_cpu_rvalid", bus.cpu_rvalid, 0);

    for (int i = 0; i < 8; i++) begin
      bus.cpu_req  = vecs[i].cpu_req;
      bus.cpu_addr = vecs[i].cpu_addr;
      #1;
      chk($sformatf("v%0d_cpu_gnt", i), bus.cpu_gnt, vecs[i].exp_gnt);
      chk($sformatf("v%0d_dbg_gnt", i), bus.dbg_gnt, 0);
      chk($sformatf("v%0d_rom_addr", i), bus.rom_addr, vecs[i].exp_rom_addr);
      @(posedge clk); #1;
      chk($sformatf("v%0d_cpu_rvalid", i), bus.cpu_rvalid, vecs[i].exp_rvalid);
      chk($sformatf("v%0d_cpu_rdata", i), bus.cpu_rdata, vecs[i].exp_rdata);
      chk($sformatf("v%0d_err", i), bus.err, vecs[i].exp_err);
      chk($sformatf("v%0d_dbg_rvalid", i), bus.dbg_rvalid, 0);
    end

    // Reset lands between a grant and its response edge.
    bus.cpu_req  = 1'b1;
    bus.cpu_addr = 32'h8;
    #1;
    chk("mid_cpu_gnt", bus.cpu_gnt, 1);
    #1;
    rst_n        = 1'b0;
    bus.cpu_req  = 1'b0;
    bus.cpu_addr = 32'h0;
    #1;
    chk("mid_cpu_rvalid", bus.cpu_rvalid, 0);
    chk("mid_cpu_rdata", bus.cpu_rdata, 0);
    chk("mid_err", bus.err, 0);
    @(posedge clk); #1;
    chk("mid_rst_edge_rvalid", bus.cpu_rvalid, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("mid_post_rvalid", bus.cpu_rvalid, 0);
    bus.cpu_req  = 1'b1;
    bus.cpu_addr = 32'h4;
    #1;
    chk("mid_new_gnt", bus.cpu_gnt, 1);
    @(posedge clk); #1;
    chk("mid_new_rvalid", bus.cpu_rvalid, 1);
    chk("mid_new_rdata", bus.cpu_rdata, 32'h2003_0005);
    bus.cpu_req = 1'b0;

`ifdef ROM_ARB_DBG_EN
    // Both requesting: four CPU grants, one debug grant, then the pattern repeats.
    bus.cpu_req  = 1'b1;
    bus.cpu_addr = 32'h0;
    bus.dbg_req  = 1'b1;
    bus.dbg_addr = 32'h10;
    for (int c = 0; c < 10; c++) begin
      bit d;
      d = ((c % 5) == 4);
      #1;
      chk($sformatf("starve%0d_cpu_gnt", c), bus.cpu_gnt, !d);
      chk($sformatf("starve%0d_dbg_gnt", c), bus.dbg_gnt, d);
      chk($sformatf("starve%0d_rom_addr", c), bus.rom_addr, d ? 32'h10 : 32'h0);
      @(posedge clk); #1;
      chk($sformatf("starve%0d_cpu_rvalid", c), bus.cpu_rvalid, !d);
      chk($sformatf("starve%0d_dbg_rvalid", c), bus.dbg_rvalid, d);
      if (d) chk($sformatf("starve%0d_dbg_rdata", c), bus.dbg_rdata, 32'h2006_0005);
    end
    bus.cpu_req  = 1'b0;
    bus.dbg_addr = 32'h14;
    #1;
    chk("dbg_only_gnt", bus.dbg_gnt, 1);
    @(posedge clk); #1;
    chk("dbg_only_rvalid", bus.dbg_rvalid, 1);
    chk("dbg_only_rdata", bus.dbg_rdata, 32'h2007_0005);
    chk("dbg_only_cpu_rvalid", bus.cpu_rvalid, 0);
    bus.dbg_req = 1'b0;
`else
    // Debug port absent: requests on it are ignored, CPU always wins.
    bus.dbg_req  = 1'b1;
    bus.dbg_addr = 32'h4;
    for (int c = 0; c < 3; c++) begin
      #1;
      chk($sformatf("nodbg%0d_dbg_gnt", c), bus.dbg_gnt, 0);
      chk($sformatf("nodbg%0d_cpu_gnt", c), bus.cpu_gnt, 0);
      chk($sformatf("nodbg%0d_rom_addr", c), bus.rom_addr, 0);
      @(posedge clk); #1;
      chk($sformatf("nodbg%0d_dbg_rvalid", c), bus.dbg_rvalid, 0);
      chk($sformatf("nodbg%0d_dbg_rdata", c), bus.dbg_rdata, 0);
    end
    bus.cpu_req  = 1'b1;
    bus.cpu_addr = 32'h0;
    for (int c = 0; c < 6; c++) begin
      #1;
      chk($sformatf("nodbg_cpu%0d_gnt", c), bus.cpu_gnt, 1);
      chk($sformatf("nodbg_cpu%0d_dbg_gnt", c), bus.dbg_gnt, 0);
      @(posedge clk); #1;
      chk($sformatf("nodbg_cpu%0d_rvalid", c), bus.cpu_rvalid, 1);
      chk($sformatf("nodbg_cpu%0d_dbg_rvalid", c), bus.dbg_rvalid, 0);
    end
    bus.cpu_req = 1'b0;
    bus.dbg_req = 1'b0;
`endif

    @(posedge clk); #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
